// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter sharing one uart_tx among NumReq byte streams
// Optional UART_ARB_TIMEOUT_EN: forced release (timeout_pulse) after TimeoutCycles-1 idle owned cycles.
module uart_tx_arbiter #(
   parameter int NumReq        = 4,
   parameter int TimeoutCycles = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NumReq-1:0][7:0] req_data,
   input  logic [NumReq-1:0]      req_valid,
   input  logic [NumReq-1:0]      req_last,
   output logic [NumReq-1:0]      req_ready,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic [NumReq-1:0]      grant,
   output logic                   busy
`ifdef UART_ARB_TIMEOUT_EN
   ,
   output logic                   timeout_pulse
`endif
);

   localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

   if (NumReq < 2 || NumReq > 8 || TimeoutCycles < 2 || TimeoutCycles > 65536) begin : g_cfg_check
      $error("uart_tx_arbiter: unsupported NumReq/TimeoutCycles");
   end

   typedef enum logic {
      S_IDLE,
      S_OWNED
   } state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   owner_q, owner_d;
   logic [IdxW-1:0]   last_q, last_d;
   logic [NumReq-1:0] grant_q, grant_d;

   logic [IdxW-1:0]   pick;
   logic              pick_vld;
   logic              owned;
   logic              xfer;
   logic              timeout;

   assign owned = (state_q == S_OWNED);
   assign xfer  = owned && !rst && req_valid[owner_q] && tx_ready;
   assign grant = grant_q;
   assign busy  = owned;

   // Round-robin search starting just above the previous owner, with wrap.
   always_comb begin
      int j;
      pick     = '0;
      pick_vld = 1'b0;
      j        = 0;
      for (int k = 1; k <= NumReq; k++) begin
         j = int'(last_q) + k;
         if (j >= NumReq) begin
            j = j - NumReq;
         end
         if (!pick_vld && req_valid[IdxW'(j)]) begin
            pick     = IdxW'(j);
            pick_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      grant_d = grant_q;
      case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               state_d       = S_OWNED;
               owner_d       = pick;
               grant_d       = '0;
               grant_d[pick] = 1'b1;
            end
         end
         S_OWNED: begin
            if ((xfer && req_last[owner_q]) || timeout) begin
               state_d = S_IDLE;
               last_d  = owner_q;
               grant_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // Data path is steered by the owner; handshakes are suppressed while rst is high.
   always_comb begin
      tx_data   = 8'h00;
      tx_valid  = 1'b0;
      req_ready = '0;
      if (owned) begin
         tx_data = req_data[owner_q];
         if (!rst) begin
            tx_valid           = req_valid[owner_q];
            req_ready[owner_q] = tx_ready;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         owner_q <= '0;
         last_q  <= IdxW'(NumReq - 1);
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         grant_q <= grant_d;
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;

   assign timeout       = owned && (cnt_q == 16'(TimeoutCycles - 1));
   assign timeout_pulse = timeout;

   // Held at zero outside OWNED so every new grant starts from a clean count.
   always_comb begin
      cnt_d = cnt_q;
      if (!owned || xfer) begin
         cnt_d = '0;
      end else if (!req_valid[owner_q] && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one `uart_tx` transmitter among NumReq byte-stream requesters, for example a console, a debug monitor and a trace unit.
- Arbitration is packet-granular and round-robin. Once a requester is granted, it keeps the transmitter until it hands over a byte marked last. This keeps multi-byte messages contiguous on the serial line.
- Sits between the requesters and `uart_tx.data_in` / `data_in_valid` / `ready`.

Parameters:
- NumReq, 4, number of requesters (2..8).
- TimeoutCycles, 1024, idle cycles before a forced release. Used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high; clock clk
- req_data  in  NumReq x 8  per-requester byte (packed array, index i = requester i)
- req_valid  in  NumReq  per-requester byte valid
- req_last  in  NumReq  byte is the final byte of the requester's packet
- req_ready  out  NumReq  per-requester accept
- tx_data  out  8  byte to `uart_tx.data_in`
- tx_valid  out  1  to `uart_tx.data_in_valid`
- tx_ready  in  1  from `uart_tx.ready`
- grant  out  NumReq  one-hot current owner; all zero when idle
- busy  out  1  high while a grant is held

Behaviour:
- Handshake: a byte transfers in any cycle where `tx_valid && tx_ready`; the same cycle gives `req_valid[g] && req_ready[g]`, with g the granted index.
- FSM state IDLE:
  - `grant` = 0, `tx_valid` = 0, `req_ready` = 0.
  - If any `req_valid` is high, choose the first valid index searching upward, with wrap, from `last_grant+1`.
  - Register the choice into `grant` and go to OWNED.
  - Arbitration latency is 1 cycle: valid in cycle N, earliest transfer in cycle N+1.
- FSM state OWNED(g):
  - Combinational paths: `tx_data = req_data[g]`, `tx_valid = req_valid[g]`, `req_ready[g] = tx_ready`. All other `req_ready` bits are 0.
  - On a transfer with `req_last[g] = 1`: `last_grant <= g`, `grant <= 0`, go to IDLE.
  - After releasing, the next arbitration happens in the IDLE cycle that follows, so there is a 1-cycle bubble between packets.
- Mid-packet gaps: if `req_valid[g]` drops before last, the grant is held indefinitely (lock) and no other requester is served. This is the behaviour without the optional feature.
- Fairness: `last_grant` resets to NumReq-1, so requester 0 wins first after reset. With all requesters continuously valid, the grant order is 0,1,…,NumReq-1,0,…
- Single requester: re-granted after each packet, with the 1-cycle bubble.
- Other requesters' `req_valid` changes during OWNED: ignored; they are only sampled in IDLE.
- A `req_last` with no `req_valid`: ignored.
- Reset values: state IDLE, `grant` = 0, `busy` = 0, `tx_valid` = 0, `req_ready` = 0, `tx_data` = 0 (forced 0 whenever not OWNED), `last_grant` = NumReq-1.
- Reset mid-packet:
  - The grant drops in the cycle after `rst` is sampled.
  - `tx_valid` and all `req_ready` are forced 0 while `rst` is high.
  - No partial-packet recovery is attempted.
- `busy` = (state == OWNED).

Optional Feature:
- Macro: `UART_ARB_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on every transfer and on entry to OWNED.
  - It increments each OWNED cycle in which `req_valid[g]` is 0.
  - When it reaches TimeoutCycles-1, the grant is released as if last had been sent (`last_grant <= g`, go to IDLE) and `timeout_pulse` is asserted for 1 cycle. `timeout_pulse` is an extra 1-bit output port that exists only when the macro is defined.
  - The counter saturates and never wraps.
- Undefined: no counter, no `timeout_pulse` port, and the grant is held until last.

Test Plan:
- Single requester: req 0 sends "Hi\n" with last on '\n' and `tx_ready` always 1 → `tx_data` sequence 0x48, 0x69, 0x0A; grant = 4'b0001 for 3 cycles; then IDLE; `busy` low 1 cycle after '\n'.
- Contention: reqs 0 and 2 both valid in cycle 0 with 2-byte packets → req 0 is granted first, both bytes go out contiguously, 1 bubble, then req 2 is granted. Req 2 bytes never interleave.
- Round-robin: all 4 reqs send 1-byte packets continuously for 12 packets → grant order 0,1,2,3,0,1,2,3,0,1,2,3.
- Backpressure: `tx_ready` toggles 1,0,0,1 while req 1 holds `valid` → `req_ready[1]` mirrors `tx_ready` exactly; `tx_data` is stable while `tx_ready` = 0; no byte is duplicated or lost.
- Reset mid-packet: `rst` is asserted after byte 2 of a 5-byte packet from req 3 → next cycle `grant` = 0 and `tx_valid` = 0. After release, req 0 wins first.
- With `UART_ARB_TIMEOUT_EN` and TimeoutCycles = 8: req 1 sends 1 byte (no last), then idles → `timeout_pulse` fires on the 8th idle cycle and the pending req 2 is granted the cycle after.
